// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared types and constants for the pipeline hazard controller
package pipe_pkg;

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_WAIT = 2'd1,
        ST_ERR  = 2'd2
    } hz_state_t;

    localparam logic [1:0] FWD_RF    = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b10;
    localparam logic [1:0] FWD_MEMWB = 2'b01;

    localparam logic [4:0] REG_ZERO = 5'd0;

    // Register 0 is hardwired, so it never creates a dependency.
    function automatic logic reg_match(
        input logic [4:0] src,
        input logic       src_en,
        input logic [4:0] dst,
        input logic       dst_en
    );
        return src_en && dst_en && (dst != REG_ZERO) && (src == dst);
    endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_fwd_unit.sv
// rtl/pipeline_hazard_ctrl_fwd_unit.sv - ALU operand forwarding selects, EX/MEM before MEM/WB
module fwd_unit
    import pipe_pkg::*;
(
    input  logic [4:0] ex_rs,
    input  logic [4:0] ex_rt,
    input  logic [4:0] mem_rd,
    input  logic       mem_regwrite,
    input  logic [4:0] wb_rd,
    input  logic       wb_regwrite,
    output logic [1:0] fwd_a,
    output logic [1:0] fwd_b
);

    always_comb begin
        fwd_a = FWD_RF;
        if (reg_match(ex_rs, 1'b1, mem_rd, mem_regwrite)) begin
            fwd_a = FWD_EXMEM;
        end else if (reg_match(ex_rs, 1'b1, wb_rd, wb_regwrite)) begin
            fwd_a = FWD_MEMWB;
        end
    end

    always_comb begin
        fwd_b = FWD_RF;
        if (reg_match(ex_rt, 1'b1, mem_rd, mem_regwrite)) begin
            fwd_b = FWD_EXMEM;
        end else if (reg_match(ex_rt, 1'b1, wb_rd, wb_regwrite)) begin
            fwd_b = FWD_MEMWB;
        end
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - stall/flush/freeze controller for the 5-stage pipeline
// Optional operand forwarding is enabled by defining PIPE_HAZARD_FORWARDING_EN.
module pipeline_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rs,
    input  logic             id_uses_rt,
    input  logic             id_jump,
    input  logic [4:0]       ex_rs,
    input  logic [4:0]       ex_rt,
    input  logic [4:0]       ex_rd,
    input  logic             ex_regwrite,
    input  logic             ex_memread,
    input  logic             ex_branch_taken,
    input  logic [4:0]       mem_rd,
    input  logic             mem_regwrite,
    input  logic [4:0]       wb_rd,
    input  logic             wb_regwrite,
    input  logic             dmem_req,
    input  logic             dmem_ready,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             ctrl_enable,
    output logic             idex_flush,
    output logic             pipe_freeze,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

    hz_state_t         state;
    hz_state_t         state_next;
    logic [WAIT_W-1:0] wait_cnt;
    logic [WAIT_W-1:0] wait_next;
    logic              mem_err_q;
    logic [CNT_W-1:0]  stall_q;
    logic              freeze;
    logic              load_use;
    logic [1:0]        fwd_a_raw;
    logic [1:0]        fwd_b_raw;

`ifdef PIPE_HAZARD_FORWARDING_EN
    logic unused_ex_regwrite;

    fwd_unit u_fwd (
        .ex_rs        (ex_rs),
        .ex_rt        (ex_rt),
        .mem_rd       (mem_rd),
        .mem_regwrite (mem_regwrite),
        .wb_rd        (wb_rd),
        .wb_regwrite  (wb_regwrite),
        .fwd_a        (fwd_a_raw),
        .fwd_b        (fwd_b_raw)
    );

    assign unused_ex_regwrite = ex_regwrite;
`else
    logic unused_fwd_inputs;

    assign fwd_a_raw         = FWD_RF;
    assign fwd_b_raw         = FWD_RF;
    assign unused_fwd_inputs = ^{ex_rs, ex_rt, wb_rd, wb_regwrite};
`endif

    always_comb begin
        load_use = reg_match(id_rs, id_uses_rs, ex_rd, ex_memread)
                 | reg_match(id_rt, id_uses_rt, ex_rd, ex_memread);
`ifndef PIPE_HAZARD_FORWARDING_EN
        // Without bypass paths every in-flight producer must drain to the register file.
        load_use = load_use
                 | reg_match(id_rs, id_uses_rs, ex_rd,  ex_regwrite)
                 | reg_match(id_rt, id_uses_rt, ex_rd,  ex_regwrite)
                 | reg_match(id_rs, id_uses_rs, mem_rd, mem_regwrite)
                 | reg_match(id_rt, id_uses_rt, mem_rd, mem_regwrite);
`endif
    end

    always_comb begin
        state_next = state;
        wait_next  = wait_cnt;
        freeze     = 1'b0;
        case (state)
            ST_RUN: begin
                freeze = dmem_req && !dmem_ready;
                if (freeze) begin
                    state_next = ST_WAIT;
                    wait_next  = '0;
                end
            end
            ST_WAIT: begin
                freeze = !dmem_ready;
                if (dmem_ready) begin
                    state_next = ST_RUN;
                end else if (wait_cnt == WAIT_LAST) begin
                    state_next = ST_ERR;
                end else begin
                    wait_next = wait_cnt + WAIT_W'(1);
                end
            end
            ST_ERR: begin
                freeze = 1'b1;
            end
            default: begin
                state_next = ST_RUN;
            end
        endcase
    end

    // A frozen EX holds any taken branch until the first unfrozen cycle.
    always_comb begin
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        ifid_flush  = 1'b0;
        ctrl_enable = 1'b1;
        idex_flush  = 1'b0;
        pipe_freeze = 1'b0;
        if (reset) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            ctrl_enable = 1'b0;
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
        end else if (freeze) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            pipe_freeze = 1'b1;
        end else if (ex_branch_taken) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
        end else if (load_use) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            ctrl_enable = 1'b0;
        end else if (id_jump) begin
            ifid_flush = 1'b1;
        end
    end

    assign fwd_a     = reset ? FWD_RF : fwd_a_raw;
    assign fwd_b     = reset ? FWD_RF : fwd_b_raw;
    assign mem_err   = mem_err_q;
    assign stall_cnt = stall_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_RUN;
            wait_cnt  <= '0;
            mem_err_q <= 1'b0;
            stall_q   <= '0;
        end else begin
            state    <= state_next;
            wait_cnt <= wait_next;
            if (state_next == ST_ERR) begin
                mem_err_q <= 1'b1;
            end
            if (!pc_write && (stall_q != {CNT_W{1'b1}})) begin
                stall_q <= stall_q + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb/tb_pipeline_hazard_ctrl.sv - self-checking bench for pipeline_hazard_ctrl
module tb_pipeline_hazard_ctrl;

    localparam int TIMEOUT = 4;
    localparam int CNT_W   = 6;
    localparam int SAT     = (1 << CNT_W) - 1;

    typedef struct packed {
        logic [4:0] id_rs;
        logic [4:0] id_rt;
        logic       id_uses_rs;
        logic       id_uses_rt;
        logic       id_jump;
        logic [4:0] ex_rs;
        logic [4:0] ex_rt;
        logic [4:0] ex_rd;
        logic       ex_regwrite;
        logic       ex_memread;
        logic       ex_branch_taken;
        logic [4:0] mem_rd;
        logic       mem_regwrite;
        logic [4:0] wb_rd;
        logic       wb_regwrite;
        logic       dmem_req;
        logic       dmem_ready;
    } in_t;

    typedef struct packed {
        logic       pc_write;
        logic       ifid_write;
        logic       ifid_flush;
        logic       ctrl_enable;
        logic       idex_flush;
        logic       pipe_freeze;
        logic [1:0] fwd_a;
        logic [1:0] fwd_b;
        logic       mem_err;
    } out_t;

    typedef struct {
        in_t        stim;
        logic [5:0] ctl;
        string      name;
    } vec_t;

    // {pc_write, ifid_write, ifid_flush, ctrl_enable, idex_flush, pipe_freeze}
    localparam logic [5:0] RUNV  = 6'b110100;
    localparam logic [5:0] STALL = 6'b000000;
    localparam logic [5:0] BRV   = 6'b111110;
    localparam logic [5:0] JMPV  = 6'b111100;
    localparam logic [5:0] FRZ   = 6'b000101;
    localparam logic [5:0] RSTV  = 6'b001010;
`ifdef PIPE_HAZARD_FORWARDING_EN
    localparam logic [5:0] RAW_EXP = RUNV;
    localparam logic [1:0] FA_MEM  = 2'b10;
    localparam logic [1:0] FA_WB   = 2'b01;
`else
    localparam logic [5:0] RAW_EXP = STALL;
    localparam logic [1:0] FA_MEM  = 2'b00;
    localparam logic [1:0] FA_WB   = 2'b00;
`endif

    logic             clk;
    logic             reset;
    in_t              cur;
    logic             pc_write, ifid_write, ifid_flush, ctrl_enable, idex_flush, pipe_freeze;
    logic [1:0]       fwd_a, fwd_b;
    logic             mem_err;
    logic [CNT_W-1:0] stall_cnt;
    out_t             act;

    int total = 0;
    int bad   = 0;

    pipeline_hazard_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk             (clk),
        .reset           (reset),
        .id_rs           (cur.id_rs),
        .id_rt           (cur.id_rt),
        .id_uses_rs      (cur.id_uses_rs),
        .id_uses_rt      (cur.id_uses_rt),
        .id_jump         (cur.id_jump),
        .ex_rs           (cur.ex_rs),
        .ex_rt           (cur.ex_rt),
        .ex_rd           (cur.ex_rd),
        .ex_regwrite     (cur.ex_regwrite),
        .ex_memread      (cur.ex_memread),
        .ex_branch_taken (cur.ex_branch_taken),
        .mem_rd          (cur.mem_rd),
        .mem_regwrite    (cur.mem_regwrite),
        .wb_rd           (cur.wb_rd),
        .wb_regwrite     (cur.wb_regwrite),
        .dmem_req        (cur.dmem_req),
        .dmem_ready      (cur.dmem_ready),
        .pc_write        (pc_write),
        .ifid_write      (ifid_write),
        .ifid_flush      (ifid_flush),
        .ctrl_enable     (ctrl_enable),
        .idex_flush      (idex_flush),
        .pipe_freeze     (pipe_freeze),
        .fwd_a           (fwd_a),
        .fwd_b           (fwd_b),
        .mem_err         (mem_err),
        .stall_cnt       (stall_cnt)
    );

    assign act = {pc_write, ifid_write, ifid_flush, ctrl_enable, idex_flush, pipe_freeze,
                  fwd_a, fwd_b, mem_err};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, a, e, $time);
        end
    endtask

    function automatic in_t hz(input logic [4:0] rs, input logic urs, input logic [4:0] rt,
                               input logic urt, input logic jmp, input logic [4:0] exrd,
                               input logic exmr, input logic exrw, input logic br,
                               input logic [4:0] memrd, input logic memrw);
        in_t v;
        v = '0;
        v.id_rs = rs;  v.id_uses_rs = urs;
        v.id_rt = rt;  v.id_uses_rt = urt;
        v.id_jump = jmp;
        v.ex_rd = exrd; v.ex_memread = exmr; v.ex_regwrite = exrw;
        v.ex_branch_taken = br;
        v.mem_rd = memrd; v.mem_regwrite = memrw;
        return v;
    endfunction

    function automatic bit hit(input logic [4:0] s, input bit su, input logic [4:0] d, input bit dw);
        return su && dw && (d != 5'd0) && (s == d);
    endfunction

    function automatic out_t model(input in_t i, input bit err, input bit rst);
        out_t o;
        bit   frz;
        bit   lu;
        o = '0;
        o.mem_err = err;
        if (rst) begin
            o.ifid_flush = 1'b1;
            o.idex_flush = 1'b1;
            return o;
        end
        frz = err || (i.dmem_req && !i.dmem_ready);
        lu  = hit(i.id_rs, i.id_uses_rs, i.ex_rd, i.ex_memread)
           || hit(i.id_rt, i.id_uses_rt, i.ex_rd, i.ex_memread);
`ifndef PIPE_HAZARD_FORWARDING_EN
        lu = lu || hit(i.id_rs, i.id_uses_rs, i.ex_rd, i.ex_regwrite)
                || hit(i.id_rt, i.id_uses_rt, i.ex_rd, i.ex_regwrite)
                || hit(i.id_rs, i.id_uses_rs, i.mem_rd, i.mem_regwrite)
                || hit(i.id_rt, i.id_uses_rt, i.mem_rd, i.mem_regwrite);
`endif
        if (frz) begin
            o.ctrl_enable = 1'b1;
            o.pipe_freeze = 1'b1;
        end else if (i.ex_branch_taken) begin
            {o.pc_write, o.ifid_write, o.ifid_flush, o.ctrl_enable, o.idex_flush} = 5'b11111;
        end else if (lu) begin
            o.pc_write = 1'b0;
        end else if (i.id_jump) begin
            {o.pc_write, o.ifid_write, o.ifid_flush, o.ctrl_enable} = 4'b1111;
        end else begin
            {o.pc_write, o.ifid_write, o.ctrl_enable} = 3'b111;
        end
`ifdef PIPE_HAZARD_FORWARDING_EN
        o.fwd_a = hit(i.ex_rs, 1'b1, i.mem_rd, i.mem_regwrite) ? 2'b10 :
                  hit(i.ex_rs, 1'b1, i.wb_rd,  i.wb_regwrite)  ? 2'b01 : 2'b00;
        o.fwd_b = hit(i.ex_rt, 1'b1, i.mem_rd, i.mem_regwrite) ? 2'b10 :
                  hit(i.ex_rt, 1'b1, i.wb_rd,  i.wb_regwrite)  ? 2'b01 : 2'b00;
`endif
        return o;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        cur   = '0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    vec_t tbl[12];
    in_t  stim;
    out_t expv;
    bit   m_err;
    bit   rst;
    int   m_run;
    int   m_stall;

    initial begin
        tbl[0]  = '{hz(8, 1, 0, 0, 0, 9, 1, 0, 0, 0, 0), RUNV,    "no_hazard"};
        tbl[1]  = '{hz(8, 1, 0, 0, 0, 8, 1, 0, 0, 0, 0), STALL,   "load_use_rs"};
        tbl[2]  = '{hz(0, 0, 8, 1, 0, 8, 1, 0, 0, 0, 0), STALL,   "load_use_rt"};
        tbl[3]  = '{hz(8, 0, 0, 0, 0, 8, 1, 0, 0, 0, 0), RUNV,    "rs_not_used"};
        tbl[4]  = '{hz(0, 1, 0, 1, 0, 0, 1, 1, 0, 0, 0), RUNV,    "reg_zero"};
        tbl[5]  = '{hz(8, 1, 0, 0, 0, 8, 1, 0, 1, 0, 0), BRV,     "branch_over_load"};
        tbl[6]  = '{hz(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0), JMPV,    "jump"};
        tbl[7]  = '{hz(8, 1, 0, 0, 1, 8, 1, 0, 0, 0, 0), STALL,   "load_over_jump"};
        tbl[8]  = '{hz(3, 1, 0, 0, 0, 3, 0, 1, 0, 0, 0), RAW_EXP, "ex_raw"};
        tbl[9]  = '{hz(0, 0, 4, 1, 0, 0, 0, 0, 0, 4, 1), RAW_EXP, "mem_raw"};
        tbl[10] = '{hz(0, 0, 4, 1, 0, 0, 0, 0, 0, 4, 0), RUNV,    "mem_no_write"};
        tbl[11] = '{hz(0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0), BRV,     "branch_over_jump"};

        reset = 1'b1;
        cur   = hz(8, 1, 0, 0, 0, 8, 1, 0, 0, 5, 1);
        cur.ex_rs = 5;
        @(posedge clk);
        @(negedge clk);
        chk("reset_outputs", act, {RSTV, 4'b0000, 1'b0});
        chk("reset_stall_cnt", stall_cnt, 0);
        reset = 1'b0;

        do_reset();
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            cur = tbl[k].stim;
            #1;
            chk(tbl[k].name, act[10:5], tbl[k].ctl);
        end

        do_reset();
        cur = hz(8, 1, 0, 0, 0, 8, 1, 0, 0, 0, 0);
        #1;
        chk("lu_bubble", act[10:5], STALL);
        @(negedge clk);
        cur = '0;
        #1;
        chk("lu_release", act[10:5], RUNV);
        chk("lu_stall_cnt", stall_cnt, 1);

        do_reset();
        for (int k = 0; k < 3; k++) begin
            cur = '0;
            cur.dmem_req = 1'b1;
            #1;
            chk("memwait_freeze", act[10:5], FRZ);
            @(negedge clk);
        end
        cur.dmem_ready = 1'b1;
        #1;
        chk("memwait_release", act[10:5], RUNV);
        chk("memwait_stall_cnt", stall_cnt, 3);
        @(negedge clk);
        cur.dmem_ready = 1'b0;
        cur.ex_branch_taken = 1'b1;
        #1;
        chk("branch_held_by_freeze", act[10:5], FRZ);
        @(negedge clk);
        cur.dmem_ready = 1'b1;
        #1;
        chk("branch_after_freeze", act[10:5], BRV);
        @(negedge clk);
        cur.ex_branch_taken = 1'b0;
        #1;
        chk("ready_same_cycle", act[10:5], RUNV);
        chk("stall_cnt_after_wait", stall_cnt, 4);
        @(negedge clk);
        cur = '0;
        #1;
        chk("zero_stall_cnt", stall_cnt, 4);

        do_reset();
        cur.dmem_req = 1'b1;
        for (int k = 0; k < TIMEOUT + 1; k++) begin
            #1;
            chk("timeout_freeze", pipe_freeze, 1);
            chk("timeout_no_err_yet", mem_err, 0);
            @(negedge clk);
        end
        #1;
        chk("timeout_err", mem_err, 1);
        @(negedge clk);
        cur = '0;
        cur.dmem_ready = 1'b1;
        #1;
        chk("err_sticky", mem_err, 1);
        chk("err_frozen", act[10:5], FRZ);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("err_reset_outputs", act[10:5], RSTV);
        @(negedge clk);
        reset = 1'b0;
        cur = '0;
        #1;
        chk("err_cleared", mem_err, 0);
        chk("err_run", act[10:5], RUNV);

        @(negedge clk);
        cur = '0;
        cur.ex_rs = 5; cur.mem_rd = 5; cur.mem_regwrite = 1'b1;
        cur.wb_rd = 5; cur.wb_regwrite = 1'b1;
        #1;
        chk("fwd_a_exmem", fwd_a, FA_MEM);
        chk("fwd_b_idle", fwd_b, 2'b00);
        @(negedge clk);
        cur.mem_regwrite = 1'b0;
        cur.ex_rt = 5;
        #1;
        chk("fwd_a_memwb", fwd_a, FA_WB);
        chk("fwd_b_memwb", fwd_b, FA_WB);
        @(negedge clk);
        cur.wb_rd = 0;
        #1;
        chk("fwd_a_zero", fwd_a, 2'b00);

        do_reset();
        cur = hz(8, 1, 0, 0, 0, 8, 1, 0, 0, 0, 0);
        repeat (SAT + 7) @(negedge clk);
        #1;
        chk("stall_cnt_saturate", stall_cnt, SAT);

        do_reset();
        m_err = 1'b0;
        m_run = 0;
        m_stall = 0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            rst = ($urandom_range(0, 99) == 0);
            stim = '0;
            stim.id_rs           = 5'($urandom_range(0, 3));
            stim.id_rt           = 5'($urandom_range(0, 3));
            stim.id_uses_rs      = 1'($urandom_range(0, 1));
            stim.id_uses_rt      = 1'($urandom_range(0, 1));
            stim.id_jump         = ($urandom_range(0, 7) == 0);
            stim.ex_rs           = 5'($urandom_range(0, 3));
            stim.ex_rt           = 5'($urandom_range(0, 3));
            stim.ex_rd           = 5'($urandom_range(0, 3));
            stim.ex_regwrite     = 1'($urandom_range(0, 1));
            stim.ex_memread      = ($urandom_range(0, 3) == 0);
            stim.ex_branch_taken = ($urandom_range(0, 7) == 0);
            stim.mem_rd          = 5'($urandom_range(0, 3));
            stim.mem_regwrite    = 1'($urandom_range(0, 1));
            stim.wb_rd           = 5'($urandom_range(0, 3));
            stim.wb_regwrite     = 1'($urandom_range(0, 1));
            stim.dmem_req        = ($urandom_range(0, 3) == 0);
            stim.dmem_ready      = 1'($urandom_range(0, 1));
            if (m_run > 0 && !m_err) stim.dmem_req = 1'b1;
            reset = rst;
            cur   = stim;
            #1;
            expv = model(stim, m_err, rst);
            chk("rand_outputs", act, expv);
            chk("rand_stall_cnt", stall_cnt, m_stall);
            if (rst) begin
                m_err = 1'b0;
                m_run = 0;
                m_stall = 0;
            end else begin
                if (!expv.pc_write && m_stall < SAT) m_stall++;
                if (!expv.pipe_freeze) begin
                    m_run = 0;
                end else if (!m_err) begin
                    m_run++;
                    if (m_run == TIMEOUT + 1) m_err = 1'b1;
                end
            end
        end
        reset = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
